eth_crc32_par: RTL and testbench

Parallel, byte-enabled Ethernet CRC-32 engine for the MAC datapath. It processes DATA_W bits per clock instead of one. It frames its own computation from sof/eof markers and produces the FCS to append on TX, or a pass/fail verdict on RX against the CRC-32 residue. It sits beside the TX/RX byte streams and observes beats in parallel; it never stalls the stream.

---
 rtl/eth_crc32_par.sv | 151 +++++++++++++++
 tb/tb_eth_crc32_par.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_crc32_par.sv
// Parallel byte-enabled Ethernet CRC-32 engine: frames on sof/eof, emits the FCS
// (generate mode) or a residue verdict (check mode) one cycle after the eof beat.
module eth_crc32_par #(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    output logic                out_valid,
    output logic [31:0]         out_fcs,
    output logic                out_ok,
    output logic [15:0]         out_len,
    output logic                proto_err
);

    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   crc_reg, crc_next;
    logic [15:0]   len_reg, len_next;
    logic          mode_reg, mode_next;

    logic          out_valid_reg;
    logic [31:0]   out_fcs_reg;
    logic          out_ok_reg;
    logic [15:0]   out_len_reg;
    logic          proto_err_reg;

    logic [31:0]   crc_base;
    logic [31:0]   beat_crc;
    logic [CW-1:0] beat_cnt;
    logic [15:0]   len_base;
    logic [16:0]   len_sum;
    logic [15:0]   beat_len;
    logic [31:0]   fcs_next;
    logic          ok_next;
    logic          done_next;
    logic          perr_next;

    // One byte through the MSB-first register, data bits taken LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    // A sof beat restarts from the preset so an abandoned frame never leaks in.
    assign crc_base = in_sof ? INIT : crc_reg;
    assign len_base = in_sof ? 16'h0000 : len_reg;

    always_comb begin
        beat_crc = crc_base;
        beat_cnt = '0;
        for (int k = 0; k < NB; k++) begin
            if (in_keep[k]) begin
                beat_crc = crc_byte(beat_crc, in_data[8*k +: 8]);
                beat_cnt = beat_cnt + CW'(1);
            end
        end
    end

    assign len_sum  = {1'b0, len_base} + 17'(beat_cnt);
    assign beat_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fcs_bit
            assign fcs_next[gi] = ~beat_crc[31-gi];
        end
    endgenerate

    // Mode comes from the live input on a sof beat so single-beat frames use it too.
    assign ok_next = (in_sof ? mode : mode_reg) && (beat_crc == RESIDUE);

    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        len_next   = len_reg;
        mode_next  = mode_reg;
        done_next  = 1'b0;
        perr_next  = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                perr_next  = (state_reg == IN_FRAME);
                mode_next  = mode;
                crc_next   = beat_crc;
                len_next   = beat_len;
                done_next  = in_eof;
                state_next = in_eof ? IDLE : IN_FRAME;
            end else if (state_reg == IN_FRAME) begin
                crc_next   = beat_crc;
                len_next   = beat_len;
                done_next  = in_eof;
                state_next = in_eof ? IDLE : IN_FRAME;
            end else begin
                perr_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            crc_reg       <= INIT;
            len_reg       <= 16'h0000;
            mode_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_fcs_reg   <= 32'h0;
            out_ok_reg    <= 1'b0;
            out_len_reg   <= 16'h0000;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            crc_reg       <= crc_next;
            len_reg       <= len_next;
            mode_reg      <= mode_next;
            out_valid_reg <= done_next;
            proto_err_reg <= perr_next;
            if (done_next) begin
                out_fcs_reg <= fcs_next;
                out_ok_reg  <= ok_next;
                out_len_reg <= beat_len;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_fcs   = out_fcs_reg;
    assign out_ok    = out_ok_reg;
    assign out_len   = out_len_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_eth_crc32_par.sv
// Scoreboard bench for eth_crc32_par: directed frames on a 32-bit instance and
// random frames on 8/64/512-bit instances against a bit-serial reference.
`timescale 1ns/1ps
module tb_eth_crc32_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] fcs;
        logic [15:0] len;
        logic        ok;
        int          at;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ b[j][i];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        for (int i = 0; i < 32; i++) r[i] = ~c[31-i];
        return r;
    endfunction

    // ---------------- directed 32-bit instance ----------------
    logic        d_reset, d_mode, d_valid, d_sof, d_eof;
    logic [31:0] d_data;
    logic [3:0]  d_keep;
    logic        d_ov, d_ok, d_perr;
    logic [31:0] d_fcs;
    logic [15:0] d_len;
    exp_t        dq[$];
    exp_t        d_e;
    int          d_ov_cnt   = 0;
    int          d_perr_cnt = 0;

    eth_crc32_par #(.DATA_W(32)) u_dut (
        .clk(clk), .reset(d_reset), .mode(d_mode), .in_valid(d_valid),
        .in_sof(d_sof), .in_eof(d_eof), .in_data(d_data), .in_keep(d_keep),
        .out_valid(d_ov), .out_fcs(d_fcs), .out_ok(d_ok), .out_len(d_len),
        .proto_err(d_perr)
    );

    always @(negedge clk) begin
        if (d_perr) d_perr_cnt++;
        if (d_ov) begin
            d_ov_cnt++;
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d_unexpected_valid got fcs=%h required no out_valid", d_fcs);
            end else begin
                d_e = dq.pop_front();
                chk("d_fcs", d_fcs, d_e.fcs);
                chk("d_len", d_len, d_e.len);
                chk("d_ok", d_ok, d_e.ok);
                chk("d_latency", cyc, d_e.at);
                $display("d frame fcs=%h len=%0d ok=%0b", d_fcs, d_len, d_ok);
            end
        end
    end

    task automatic push_d(input logic [31:0] f, input logic [15:0] l, input logic o);
        exp_t e;
        e.fcs = f; e.len = l; e.ok = o; e.at = cyc + 1;
        dq.push_back(e);
    endtask

    task automatic beat(input logic s, input logic e, input logic [31:0] d,
                        input logic [3:0] k, input logic m);
        d_valid = 1'b1; d_sof = s; d_eof = e; d_data = d; d_keep = k; d_mode = m;
        @(posedge clk); #1;
        d_valid = 1'b0; d_sof = 1'b0; d_eof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- random 8/64/512-bit instances ----------------
    logic r_reset;
    logic rand_done [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rand
            localparam int W  = (gi == 0) ? 8 : ((gi == 1) ? 64 : 512);
            localparam int NB = W / 8;
            logic          r_mode, r_valid, r_sof, r_eof;
            logic [W-1:0]  r_data;
            logic [NB-1:0] r_keep;
            logic          r_ov, r_ok, r_perr;
            logic [31:0]   r_fcs;
            logic [15:0]   r_len;
            exp_t          q[$];
            exp_t          m_e;

            eth_crc32_par #(.DATA_W(W)) u_dut (
                .clk(clk), .reset(r_reset), .mode(r_mode), .in_valid(r_valid),
                .in_sof(r_sof), .in_eof(r_eof), .in_data(r_data), .in_keep(r_keep),
                .out_valid(r_ov), .out_fcs(r_fcs), .out_ok(r_ok), .out_len(r_len),
                .proto_err(r_perr)
            );

            always @(negedge clk) begin
                if (r_perr) begin
                    checks++;
                    failures++;
                    $display("FAIL r%0d_proto_err got=1 required=0", W);
                end
                if (r_ov) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL r%0d_unexpected_valid got fcs=%h required none", W, r_fcs);
                    end else begin
                        m_e = q.pop_front();
                        chk($sformatf("r%0d_fcs", W), r_fcs, m_e.fcs);
                        chk($sformatf("r%0d_len", W), r_len, m_e.len);
                        chk($sformatf("r%0d_ok", W), r_ok, m_e.ok);
                        chk($sformatf("r%0d_latency", W), cyc, m_e.at);
                        $display("r%0d frame fcs=%h len=%0d ok=%0b", W, r_fcs, r_len, r_ok);
                    end
                end
            end

            initial begin : drive
                logic [7:0]  bytes[$];
                logic [31:0] fcs;
                exp_t        e;
                int          n, nbeats, idx;
                logic        cm;
                rand_done[gi] = 1'b0;
                r_mode = 1'b0; r_valid = 1'b0; r_sof = 1'b0; r_eof = 1'b0;
                r_data = '0; r_keep = '0;
                repeat (6) @(posedge clk);
                #1;
                for (int f = 0; f < 6; f++) begin
                    n  = (f == 0) ? 1 : ((f == 1) ? 1518 : int'($urandom_range(1518, 1)));
                    cm = (f % 2 == 1);
                    bytes.delete();
                    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
                    fcs = ref_fcs(bytes);
                    if (cm) begin
                        for (int i = 0; i < 4; i++) bytes.push_back(fcs[8*i +: 8]);
                        e.fcs = 32'h2144DF1C;
                        e.ok  = 1'b1;
                    end else begin
                        e.fcs = fcs;
                        e.ok  = 1'b0;
                    end
                    e.len  = 16'(bytes.size());
                    nbeats = (bytes.size() + NB - 1) / NB;
                    for (int b = 0; b < nbeats; b++) begin
                        r_data = '0;
                        r_keep = '0;
                        for (int k = 0; k < NB; k++) begin
                            idx = b * NB + k;
                            if (idx < bytes.size()) begin
                                r_data[8*k +: 8] = bytes[idx];
                                r_keep[k] = 1'b1;
                            end
                        end
                        r_valid = 1'b1;
                        r_sof   = (b == 0);
                        r_eof   = (b == nbeats - 1);
                        r_mode  = (b == 0) ? cm : 1'($urandom);
                        if (r_eof) begin
                            e.at = cyc + 1;
                            q.push_back(e);
                        end
                        @(posedge clk); #1;
                        r_valid = 1'b0; r_sof = 1'b0; r_eof = 1'b0;
                        if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
                    end
                end
                repeat (4) @(posedge clk);
                rand_done[gi] = 1'b1;
            end
        end
    endgenerate

    // ---------------- directed sequence and summary ----------------
    initial begin : main
        logic [7:0] msg[$];
        int p0, v0, t;
        r_reset = 1'b1;
        d_reset = 1'b1;
        d_mode = 1'b0; d_valid = 1'b0; d_sof = 1'b0; d_eof = 1'b0;
        d_data = '0; d_keep = '0;
        repeat (3) @(posedge clk);
        #1;
        r_reset = 1'b0;
        d_reset = 1'b0;
        idle(2);

        chk("reset_out_valid", d_ov, 1'b0);
        chk("reset_out_fcs", d_fcs, 32'h0);
        chk("reset_out_ok", d_ok, 1'b0);
        chk("reset_out_len", d_len, 16'h0);
        chk("reset_proto_err", d_perr, 1'b0);

        // "123456789" generate
        beat(1, 0, 32'h34333231, 4'b1111, 0);
        beat(0, 0, 32'h38373635, 4'b1111, 0);
        push_d(32'hCBF43926, 16'd9, 1'b0);
        beat(0, 1, 32'h00000039, 4'b0001, 0);
        idle(2);

        // check mode, correct FCS; mode input wiggles after sof
        beat(1, 0, 32'h34333231, 4'b1111, 1);
        beat(0, 0, 32'h38373635, 4'b1111, 0);
        beat(0, 0, 32'h00000039, 4'b0001, 0);
        push_d(32'h2144DF1C, 16'd13, 1'b1);
        beat(0, 1, 32'hCBF43926, 4'b1111, 0);
        idle(2);

        // check mode, one FCS bit flipped
        for (int i = 1; i <= 9; i++) msg.push_back(8'(8'h30 + i));
        msg.push_back(8'h27); msg.push_back(8'h39); msg.push_back(8'hF4); msg.push_back(8'hCB);
        beat(1, 0, 32'h34333231, 4'b1111, 1);
        beat(0, 0, 32'h38373635, 4'b1111, 1);
        beat(0, 0, 32'h00000039, 4'b0001, 1);
        push_d(ref_fcs(msg), 16'd13, 1'b0);
        beat(0, 1, 32'hCBF43927, 4'b1111, 1);
        idle(2);

        // back-to-back single-beat frames
        msg.delete();
        for (int i = 1; i <= 4; i++) msg.push_back(8'(8'h30 + i));
        push_d(ref_fcs(msg), 16'd4, 1'b0);
        beat(1, 1, 32'h34333231, 4'b1111, 0);
        push_d(32'h83DCEFB7, 16'd1, 1'b0);
        beat(1, 1, 32'h00000031, 4'b0001, 0);
        idle(3);

        // beat without sof while idle
        p0 = d_perr_cnt; v0 = d_ov_cnt;
        beat(0, 1, 32'h12345678, 4'b1111, 0);
        idle(3);
        chk("idle_beat_proto_err", d_perr_cnt, p0 + 1);
        chk("idle_beat_no_valid", d_ov_cnt, v0);

        // sof in the middle of a frame
        p0 = d_perr_cnt;
        beat(1, 0, 32'hDEADBEEF, 4'b1111, 0);
        beat(0, 0, 32'h01020304, 4'b1111, 0);
        beat(1, 0, 32'h34333231, 4'b1111, 0);
        beat(0, 0, 32'h38373635, 4'b1111, 0);
        push_d(32'hCBF43926, 16'd9, 1'b0);
        beat(0, 1, 32'h00000039, 4'b0001, 0);
        idle(3);
        chk("mid_sof_proto_err", d_perr_cnt, p0 + 1);

        // reset mid-frame
        v0 = d_ov_cnt;
        beat(1, 0, 32'h34333231, 4'b1111, 0);
        beat(0, 0, 32'h38373635, 4'b1111, 0);
        d_reset = 1'b1;
        idle(1);
        d_reset = 1'b0;
        idle(1);
        chk("mid_reset_out_valid", d_ov, 1'b0);
        chk("mid_reset_out_fcs", d_fcs, 32'h0);
        chk("mid_reset_out_ok", d_ok, 1'b0);
        chk("mid_reset_out_len", d_len, 16'h0);
        chk("mid_reset_proto_err", d_perr, 1'b0);
        p0 = d_perr_cnt;
        beat(0, 1, 32'h00000039, 4'b0001, 0);
        idle(3);
        chk("mid_reset_no_valid", d_ov_cnt, v0);
        chk("mid_reset_idle_state", d_perr_cnt, p0 + 1);
        chk("directed_queue_empty", dq.size(), 0);

        t = 0;
        while (!(rand_done[0] && rand_done[1] && rand_done[2]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk("rand_done_8", rand_done[0], 1'b1);
        chk("rand_done_64", rand_done[1], 1'b1);
        chk("rand_done_512", rand_done[2], 1'b1);
        chk("rand_q_empty_8", g_rand[0].q.size(), 0);
        chk("rand_q_empty_64", g_rand[1].q.size(), 0);
        chk("rand_q_empty_512", g_rand[2].q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
